// File: rtl/score_display_pkg.sv
// Shared types and constants for the multiplexed two-digit score display.
// Holds the conversion FSM states, the 7-segment glyph table and the score ceiling.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int unsigned MAX_SCORE = 99;

  // Active-high segments {g,f,e,d,c,b,a}, indexed by the BCD digit value.
  localparam logic [6:0] SEG_PATTERN [10] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

  // Double-dabble pre-shift correction for one BCD nibble.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to 7-segment pattern; non-decimal nibbles render blank.
module seg7_encode
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_PATTERN[bcd];
    end
  end

endmodule

// File: rtl/score_display_mux.sv
// Latches a binary score, converts it to two BCD digits by iterative double-dabble,
// and time-multiplexes the digit glyphs with a matching digit_sel toggle.
module score_display_mux
  import score_display_pkg::*;
#(
  parameter int SCORE_W    = 7,
  parameter int TOGGLE_DIV = 12000,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  output logic               busy,
  output logic [6:0]         seg_out,
  output logic               digit_sel
);

  localparam int CNT_W  = $clog2(SCORE_W + 1);
  localparam int SCAN_W = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;

  // Narrow scores can never exceed 99, so the limit becomes all-ones and never triggers.
  localparam logic [SCORE_W-1:0] SAT_LIMIT =
    (SCORE_W >= 7) ? SCORE_W'(MAX_SCORE) : {SCORE_W{1'b1}};

  // Conversion state
  state_t             state_q, state_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [7:0]         bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         bcd_adj;

  // Displayed digits
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;

  // Scan and output stage
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic               scan_wrap;
  logic               digit_sel_d;
  logic [3:0]         shown_nibble;
  logic [6:0]         enc_seg;
  logic [6:0]         seg_d;

  assign busy = (state_q != IDLE);

  assign bcd_adj = {dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;

    unique case (state_q)
      IDLE: begin
        if (score_valid) begin
          bin_d   = (score_in > SAT_LIMIT) ? SAT_LIMIT : score_in;
          bcd_d   = 8'h00;
          cnt_d   = CNT_W'(SCORE_W);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        bcd_d = {bcd_adj[6:0], bin_q[SCORE_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        // Both digits move together so the display never shows a half-updated score.
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scan runs freely; segments are chosen for the phase that digit_sel is about to enter.
  always_comb begin
    scan_wrap    = (scan_q == SCAN_W'(TOGGLE_DIV - 1));
    scan_d       = scan_wrap ? '0 : scan_q + SCAN_W'(1);
    digit_sel_d  = digit_sel ^ scan_wrap;
    shown_nibble = digit_sel_d ? ones_q : tens_q;
    seg_d        = enc_seg;
    if (BLANK_LZ && !digit_sel_d && (tens_q == 4'd0)) begin
      seg_d = SEG_BLANK;
    end
  end

  seg7_encode u_seg7_encode (
    .bcd (shown_nibble),
    .seg (enc_seg)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: the displayed digits are reset too, so an interrupted conversion falls back to 0/0.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= 8'h00;
      cnt_q     <= '0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      scan_q    <= '0;
      digit_sel <= 1'b0;
      seg_out   <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      scan_q    <= scan_d;
      digit_sel <= digit_sel_d;
      seg_out   <= seg_d;
    end
  end

endmodule
